// File: rtl/message_stream_combiner_rr.sv
// message_stream_combiner_rr: round-robin combiner of N buffered header+payload message streams.
// Define COMBINER_SOURCE_TAG_EN to stamp the granted stream index into forwarded headers.
module message_stream_combiner_rr #(
    parameter int N_STREAMS     = 4,
    parameter int LOG_N_STREAMS = 2,
    parameter int WDTH          = 32,
    parameter int BUF_LEN       = 64,
    parameter int LOG_BUF_LEN   = 6,
    parameter int MAX_PKT_LEN   = 32,
    parameter int MSG_LEN_WDTH  = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_STREAMS*WDTH-1:0] in_data,
    input  logic [N_STREAMS-1:0]      in_nd,
    output logic [WDTH-1:0]           out_data,
    output logic                      out_nd,
    output logic                      error
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state;
    logic [LOG_N_STREAMS-1:0] last_grant, sel, gnt;
    logic [MSG_LEN_WDTH-1:0] remaining, hdr_len;
    logic [N_STREAMS-1:0] nonempty, full, pop, ovf;
    logic [N_STREAMS*WDTH-1:0] heads;
    logic [WDTH-1:0] word, fwd;
    logic found, gap, go;

    for (genvar k = 0; k < N_STREAMS; k++) begin : g_fifo
        logic [WDTH-1:0] mem [BUF_LEN];
        logic [LOG_BUF_LEN:0] wr_ptr, rd_ptr;
        logic wr_ok;
        assign nonempty[k] = wr_ptr != rd_ptr;
        assign full[k] = (wr_ptr ^ rd_ptr) == {1'b1, {LOG_BUF_LEN{1'b0}}};
        assign pop[k] = go && gnt == LOG_N_STREAMS'(k);
        // a full FIFO still accepts a write when it pops in the same cycle
        assign wr_ok = in_nd[k] && (!full[k] || pop[k]);
        assign ovf[k] = in_nd[k] && !wr_ok;
        assign heads[k*WDTH +: WDTH] = mem[rd_ptr[LOG_BUF_LEN-1:0]];
        always_ff @(posedge clk)
            if (wr_ok) mem[wr_ptr[LOG_BUF_LEN-1:0]] <= in_data[k*WDTH +: WDTH];
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop[k]) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // descending scan so the nearest non-empty stream after last_grant wins
    always_comb begin
        sel = last_grant;
        found = 1'b0;
        for (int i = N_STREAMS; i >= 1; i--) begin
            if (nonempty[LOG_N_STREAMS'((int'(last_grant) + i) % N_STREAMS)]) begin
                sel = LOG_N_STREAMS'((int'(last_grant) + i) % N_STREAMS);
                found = 1'b1;
            end
        end
    end

    assign gnt = (state == SEND) ? last_grant : sel;
    assign go = (state == SEND) ? nonempty[last_grant] : found && !gap;
    assign word = heads[gnt*WDTH +: WDTH];
    assign hdr_len = word[MSG_LEN_WDTH-1:0];

`ifdef COMBINER_SOURCE_TAG_EN
    always_comb begin
        fwd = word;
        if (state == IDLE) fwd[MSG_LEN_WDTH +: LOG_N_STREAMS] = gnt;
    end
`else
    assign fwd = word;
`endif

    // gap blocks arbitration for one cycle after a packet completes
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            last_grant <= LOG_N_STREAMS'(N_STREAMS - 1);
            out_nd     <= 1'b0;
            out_data   <= '0;
            error      <= 1'b0;
            gap        <= 1'b0;
        end else begin
            out_nd <= go;
            if (go) out_data <= fwd;
            gap <= 1'b0;
            if (|ovf) error <= 1'b1;
            if (state == IDLE) begin
                if (go) begin
                    last_grant <= sel;
                    if (int'(hdr_len) > MAX_PKT_LEN) error <= 1'b1;
                    if (hdr_len != '0) begin
                        state     <= SEND;
                        remaining <= hdr_len;
                    end else gap <= 1'b1;
                end
            end else if (go) begin
                remaining <= remaining - 1'b1;
                if (remaining == MSG_LEN_WDTH'(1)) begin
                    state <= IDLE;
                    gap   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_message_stream_combiner_rr.sv
// tb_message_stream_combiner_rr: directed scenarios for the round-robin stream combiner.
module tb_message_stream_combiner_rr;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [127:0] in_data = '0;
    logic [3:0] in_nd = '0;
    logic [31:0] out_data;
    logic out_nd;
    logic error;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] obs_d[$];
    int obs_c[$];

    message_stream_combiner_rr dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_nd(in_nd),
        .out_data(out_data), .out_nd(out_nd), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (out_nd === 1'b1) begin
            obs_d.push_back(out_data);
            obs_c.push_back(cyc);
        end

    function automatic logic [127:0] pk(input int s, input logic [31:0] w);
        return {96'b0, w} << (s * 32);
    endfunction

    function automatic logic [31:0] eh(input int s, input logic [31:0] r);
        logic [31:0] x;
        x = r;
`ifdef COMBINER_SOURCE_TAG_EN
        x[7:6] = 2'(s);
`endif
        return x;
    endfunction

    task automatic put(input logic [3:0] nd, input logic [127:0] d);
        in_nd = nd;
        in_data = d;
        @(posedge clk);
        #1;
        in_nd = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) put(4'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        put(4'b1111, {4{32'hFFFF_FFC5}});
        reset = 1'b0;
        obs_d.delete();
        obs_c.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (out_nd !== 1'b0) $display("FAIL reset_out_nd: got %b want 0", out_nd); else n_pass++;
        n_chk++;
        if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_chk++;
        if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
        idle(5);
        n_chk++;
        if (obs_d.size() !== 0) $display("FAIL reset_ignored_in_nd: got %0d words want 0", obs_d.size()); else n_pass++;
    endtask

    task automatic test_single();
        logic [31:0] ew[4];
        int t0;
        do_reset();
        ew = '{32'h0000_AB03, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
        t0 = cyc;
        for (int i = 0; i < 4; i++) put(4'b0001, pk(0, ew[i]));
        idle(6);
        n_chk++;
        if (obs_d.size() !== 4) $display("FAIL single_count: got %0d want 4", obs_d.size()); else n_pass++;
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[i] !== eh(0, ew[i])) $display("FAIL single_data[%0d]: got %h want %h", i, obs_d[i], eh(0, ew[i])); else n_pass++;
            n_chk++;
            if (obs_c[i] !== t0 + 2 + i) $display("FAIL single_time[%0d]: got %0d want %0d", i, obs_c[i], t0 + 2 + i); else n_pass++;
        end
        n_chk++;
        if (error !== 1'b0) $display("FAIL single_error: got %b want 0", error); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [31:0] ew[$];
        int ec[$];
        logic [127:0] d;
        int t0;
        do_reset();
        t0 = cyc;
        for (int c = 0; c < 6; c++) begin
            d = '0;
            for (int s = 0; s < 4; s++)
                d |= pk(s, (c % 3 == 0) ? (32'(s) << 24) | (32'(c / 3) << 20) | 32'd2
                                        : (32'(s) << 24) | (32'(c / 3) << 20) | 32'h100 | 32'(c % 3));
            put(4'b1111, d);
        end
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 3; j++) begin
                ew.push_back(j == 0 ? eh(k % 4, (32'(k % 4) << 24) | (32'(k / 4) << 20) | 32'd2)
                                    : (32'(k % 4) << 24) | (32'(k / 4) << 20) | 32'h100 | 32'(j));
                ec.push_back(t0 + 2 + 4 * k + j);
            end
        idle(30);
        n_chk++;
        if (obs_d.size() !== 24) $display("FAIL fair_count: got %0d want 24", obs_d.size()); else n_pass++;
        for (int i = 0; i < 24 && i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[i] !== ew[i]) $display("FAIL fair_data[%0d]: got %h want %h", i, obs_d[i], ew[i]); else n_pass++;
            n_chk++;
            if (obs_c[i] !== ec[i]) $display("FAIL fair_time[%0d]: got %0d want %0d", i, obs_c[i], ec[i]); else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] ew[8];
        int ec[8];
        int t0;
        do_reset();
        t0 = cyc;
        put(4'b0010, pk(1, 32'h1100_0004));
        put(4'b0011, pk(1, 32'h1100_0A01) | pk(0, 32'h3300_0001));
        put(4'b0101, pk(0, 32'h3300_00BB) | pk(2, 32'h2200_0000));
        idle(2);
        put(4'b0010, pk(1, 32'h1100_0A02));
        idle(3);
        put(4'b0010, pk(1, 32'h1100_0A03));
        idle(3);
        put(4'b0010, pk(1, 32'h1100_0A04));
        idle(12);
        ew = '{eh(1, 32'h1100_0004), 32'h1100_0A01, 32'h1100_0A02, 32'h1100_0A03,
               32'h1100_0A04, eh(2, 32'h2200_0000), eh(0, 32'h3300_0001), 32'h3300_00BB};
        ec = '{t0 + 2, t0 + 3, t0 + 7, t0 + 11, t0 + 15, t0 + 17, t0 + 19, t0 + 20};
        n_chk++;
        if (obs_d.size() !== 8) $display("FAIL stall_count: got %0d want 8", obs_d.size()); else n_pass++;
        for (int i = 0; i < 8 && i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[i] !== ew[i]) $display("FAIL stall_data[%0d]: got %h want %h", i, obs_d[i], ew[i]); else n_pass++;
            n_chk++;
            if (obs_c[i] !== ec[i]) $display("FAIL stall_time[%0d]: got %0d want %0d", i, obs_c[i], ec[i]); else n_pass++;
        end
        n_chk++;
        if (error !== 1'b0) $display("FAIL stall_error: got %b want 0", error); else n_pass++;
        n_chk++;
        if (out_data !== 32'h3300_00BB) $display("FAIL stall_hold: got %h want 330000bb", out_data); else n_pass++;
    endtask

    task automatic test_bad_len();
        logic [31:0] w;
        int t0;
        do_reset();
        t0 = cyc;
        put(4'b1000, pk(3, 32'h5500_0021));
        for (int j = 1; j <= 33; j++) put(4'b1000, pk(3, 32'h5500_C000 | 32'(j)));
        idle(6);
        n_chk++;
        if (obs_d.size() !== 34) $display("FAIL badlen_count: got %0d want 34", obs_d.size()); else n_pass++;
        for (int i = 0; i < 34 && i < obs_d.size(); i++) begin
            w = (i == 0) ? eh(3, 32'h5500_0021) : 32'h5500_C000 | 32'(i);
            n_chk++;
            if (obs_d[i] !== w || obs_c[i] !== t0 + 2 + i)
                $display("FAIL badlen_word[%0d]: got %h@%0d want %h@%0d", i, obs_d[i], obs_c[i], w, t0 + 2 + i);
            else n_pass++;
        end
        n_chk++;
        if (error !== 1'b1) $display("FAIL badlen_error: got %b want 1", error); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] s2[64];
        do_reset();
        for (int i = 0; i < 64; i++)
            s2[i] = (i % 32 == 0) ? 32'h6600_001F : 32'h6600_5000 | 32'(i);
        put(4'b0001, pk(0, 32'h0B00_0014));
        for (int i = 0; i < 64; i++)
            put(i == 0 ? 4'b0101 : 4'b0100, pk(2, s2[i]) | pk(0, 32'h0A00_0001));
        n_chk++;
        if (error !== 1'b0) $display("FAIL ovf_error_at_full: got %b want 0", error); else n_pass++;
        put(4'b0100, pk(2, 32'hDEAD_BEEF));
        n_chk++;
        if (error !== 1'b1) $display("FAIL ovf_error_set: got %b want 1", error); else n_pass++;
        for (int j = 2; j <= 20; j++) put(4'b0001, pk(0, 32'h0A00_0000 | 32'(j)));
        idle(100);
        n_chk++;
        if (obs_d.size() !== 85) $display("FAIL ovf_count: got %0d want 85", obs_d.size()); else n_pass++;
        for (int i = 0; i < 64 && 21 + i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[21 + i] !== ((i % 32 == 0) ? eh(2, s2[i]) : s2[i]))
                $display("FAIL ovf_s2_data[%0d]: got %h want %h", i, obs_d[21 + i], (i % 32 == 0) ? eh(2, s2[i]) : s2[i]);
            else n_pass++;
        end
        n_chk++;
        if (error !== 1'b1) $display("FAIL ovf_error_sticky: got %b want 1", error); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t0;
        do_reset();
        put(4'b0010, pk(1, 32'h7700_0028));
        put(4'b0010, pk(1, 32'h7700_0001));
        put(4'b0010, pk(1, 32'h7700_0002));
        idle(1);
        n_chk++;
        if (error !== 1'b1) $display("FAIL mid_error_before: got %b want 1", error); else n_pass++;
        reset = 1'b1;
        put(4'b0010, pk(1, 32'h7700_0003));
        reset = 1'b0;
        obs_d.delete();
        obs_c.delete();
        n_chk++;
        if (out_nd !== 1'b0) $display("FAIL mid_out_nd: got %b want 0", out_nd); else n_pass++;
        n_chk++;
        if (error !== 1'b0) $display("FAIL mid_error_cleared: got %b want 0", error); else n_pass++;
        idle(4);
        n_chk++;
        if (obs_d.size() !== 0) $display("FAIL mid_flushed: got %0d words want 0", obs_d.size()); else n_pass++;
        t0 = cyc;
        put(4'b0100, pk(2, 32'h8800_0001));
        put(4'b0100, pk(2, 32'h8800_00AA));
        idle(5);
        n_chk++;
        if (obs_d.size() !== 2) $display("FAIL mid_fresh_count: got %0d want 2", obs_d.size()); else n_pass++;
        if (obs_d.size() == 2) begin
            n_chk++;
            if (obs_d[0] !== eh(2, 32'h8800_0001) || obs_c[0] !== t0 + 2)
                $display("FAIL mid_fresh_hdr: got %h@%0d want %h@%0d", obs_d[0], obs_c[0], eh(2, 32'h8800_0001), t0 + 2);
            else n_pass++;
            n_chk++;
            if (obs_d[1] !== 32'h8800_00AA || obs_c[1] !== t0 + 3)
                $display("FAIL mid_fresh_pay: got %h@%0d want 880000aa@%0d", obs_d[1], obs_c[1], t0 + 3);
            else n_pass++;
        end
        n_chk++;
        if (error !== 1'b0) $display("FAIL mid_fresh_error: got %b want 0", error); else n_pass++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_bad_len();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
